// File: rtl/bk_add_sequencer.sv
// Sequences one WIDTH-bit addition through an external SLICE-bit adder, LS slice first.
// Define BK_SEQ_SUB_EN to enable subtraction (A - B) through in_sub.
module bk_add_sequencer #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [SLICE-1:0] slice_a,
    output logic [SLICE-1:0] slice_b,
    output logic             slice_cin,
    input  logic [SLICE-1:0] slice_sum,
    input  logic             slice_cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;

`ifndef BK_SEQ_SUB_EN
    logic unused_sub;
    assign unused_sub = in_sub;
`endif

    assign in_ready = (state == IDLE);
    assign out_sum  = sum_reg;

    // The slice is only driven while an operation is running; zero otherwise.
    always_comb begin
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        if (state == RUN) begin
            slice_a   = a_reg[idx*SLICE +: SLICE];
            slice_b   = b_reg[idx*SLICE +: SLICE];
            slice_cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            out_valid <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        idx   <= '0;
                        state <= RUN;
`ifdef BK_SEQ_SUB_EN
                        if (in_sub) begin
                            b_reg <= ~in_b;
                            carry <= 1'b1;
                        end else begin
                            b_reg <= in_b;
                            carry <= in_cin;
                        end
`else
                        b_reg <= in_b;
                        carry <= in_cin;
`endif
                    end
                end
                RUN: begin
                    sum_reg[idx*SLICE +: SLICE] <= slice_sum;
                    carry                       <= slice_cout;
                    if (idx == LAST) begin
                        // Carry into the MSB is a^b^sum there; overflow is that xor carry out.
                        idx       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_cout  <= slice_cout;
                        out_ovf   <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1]
                                     ^ slice_sum[SLICE-1] ^ slice_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bk_add_sequencer.sv
// Directed bench for bk_add_sequencer (WIDTH=64) with a behavioural adder slice and a
// scoreboard of expected {ovf, cout, sum} entries.
module tb_bk_add_sequencer;

    localparam int WIDTH = 64;
    localparam int SLICE = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic             slice_cin;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH+1:0] sb_q[$];
    logic [WIDTH+1:0] cur;
    logic             cins[0:31];
    int               lat;

    bk_add_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_sum(slice_sum), .slice_cout(slice_cout)
    );

    // External combinational slice adder
    assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {16'd0, slice_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sub);
        logic [WIDTH-1:0] bb;
        logic             c;
        logic [WIDTH:0]   s;
        bb = b;
        c  = cin;
`ifdef BK_SEQ_SUB_EN
        if (sub) begin
            bb = ~b;
            c  = 1'b1;
        end
`else
        if (sub) bb = b;
`endif
        s = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
        return {(a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]), s[WIDTH], s[WIDTH-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one request and returns just after the accept edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        chk("accept_ready", 64'(in_ready), 64'd1);
        sb_q.push_back(model(a, b, cin, sub));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Waits for out_valid, recording slice_cin per RUN cycle, then scores the result.
    task automatic collect(input string tag, input int exp_lat);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
            cins[k] = slice_cin;
        end
        lat = k;
        if (k == 20) begin
            chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
        end else begin
            if (exp_lat >= 0) chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
            cur = sb_q.pop_front();
            chk({tag, "_sum"}, out_sum, cur[WIDTH-1:0]);
            chk({tag, "_cout"}, 64'(out_cout), 64'(cur[WIDTH]));
            chk({tag, "_ovf"}, 64'(out_ovf), 64'(cur[WIDTH+1]));
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_slice_a", 64'(slice_a), 64'd0);

        // Full carry ripple across every slice
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        collect("ripple", 4);
        chk("ripple_cin0", 64'(cins[0]), 64'd0);
        for (int i = 1; i < 4; i++) chk($sformatf("ripple_cin%0d", i), 64'(cins[i]), 64'd1);
        release_out();

        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        collect("ovf", 4);
        chk("ovf_sum_const", out_sum, 64'h8000_0000_0000_0000);
        release_out();

        send(64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0);
        collect("cin", 4);
        chk("cin_idx1", 64'(cins[1]), 64'd1);
        chk("cin_idx2", 64'(cins[2]), 64'd0);
        chk("cin_sum_const", out_sum, 64'h0000_0000_0001_0000);
        release_out();

        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        collect("negovf", 4);
        release_out();

        for (int r = 0; r < 6; r++) begin
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
            collect($sformatf("rand%0d", r), 4);
            release_out();
        end

        // Backpressure: result must hold while the consumer stalls
        send(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        collect("bp", 4);
        in_a     = 64'd10;
        in_b     = 64'd20;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_sum", out_sum, cur[WIDTH-1:0]);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_valid_drop", 64'(out_valid), 64'd0);
        send(64'd10, 64'd20, 1'b0, 1'b0);
        collect("bp_next", 4);
        release_out();

        // Reset mid-RUN discards the operation
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_rst_cin_idx2", 64'(slice_cin), 64'd1);
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_slice_a", 64'(slice_a), 64'd0);
        chk("mid_rst_slice_b", 64'(slice_b), 64'd0);
        chk("mid_rst_slice_cin", 64'(slice_cin), 64'd0);
        chk("mid_rst_sum", out_sum, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        send(64'd3, 64'd4, 1'b0, 1'b0);
        collect("post_rst", 4);
        chk("post_rst_seven", out_sum, 64'd7);
        release_out();

`ifdef BK_SEQ_SUB_EN
        send(64'd5, 64'd7, 1'b1, 1'b1);
        collect("sub", 4);
        chk("sub_sum_const", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        release_out();
`endif

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
